// File: rtl/alu_pkg.sv
// Shared encodings and state type for the ALU command sequencer.
// Opcodes 000-011 double as the ALU select values.
package alu_pkg;

  localparam int WIDTH = 8;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 8-bit combinational ALU: accumulator,
// single-cycle ALU ops, shift-and-add multiply, and a held response.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = alu_pkg::WIDTH,
  parameter int MUL_ITERS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_select,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam int CW = $clog2(MUL_ITERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITERS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] prod_next_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= 3'b000;
      opnd_q  <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // ALU operand routing: the multiply borrows the ADD path for prod + mcand
  always_comb begin
    if (state_q == MUL) begin
      alu_a      = prod_q;
      alu_b      = mcand_q;
      alu_select = OP_ADD;
    end else begin
      alu_a      = acc_q;
      alu_b      = opnd_q;
      alu_select = op_q;
    end
  end

  // Partial product only absorbs the shifted multiplicand on a set multiplier bit
  always_comb begin
    if (opnd_q[cnt_q]) begin
      prod_next_s = alu_result;
    end else begin
      prod_next_s = prod_q;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          opnd_d = cmd_operand;
          if (cmd_op == OP_MUL) begin
            prod_d  = '0;
            mcand_d = acc_q;
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            state_d = EXEC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        case (op_q)
          OP_AND, OP_OR, OP_ADD, OP_SUB: begin
            acc_d  = alu_result;
            zero_d = alu_zero;
            err_d  = 1'b0;
          end
          OP_LOAD: begin
            acc_d  = opnd_q;
            zero_d = (opnd_q == '0);
            err_d  = 1'b0;
          end
          OP_CLR: begin
            acc_d  = '0;
            zero_d = 1'b1;
            err_d  = 1'b0;
          end
          default: begin
            acc_d  = acc_q;
            zero_d = (acc_q == '0);
            err_d  = 1'b1;
          end
        endcase
        valid_d = 1'b1;
        state_d = RESP;
      end
      MUL: begin
        prod_d  = prod_next_s;
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          acc_d   = prod_next_s;
          zero_d  = (prod_next_s == '0);
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = RESP;
        end else begin
          state_d = MUL;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
          state_d = RESP;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = valid_q;
  assign rsp_result = acc_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 8-bit ALU alongside.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_operand;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_select;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_err;

  int n_checks;
  int n_errors;

  alu_cmd_sequencer #(.WIDTH(8), .MUL_ITERS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_select  (alu_select),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_err     (rsp_err)
  );

  // Reference ALU: operand A is the accumulator, B the command operand
  always_comb begin
    case (alu_select)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = alu_a - alu_b;
      default: alu_result = alu_a;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one command, return edges from the accept edge to rsp_valid
  task automatic send(input logic [2:0] op, input logic [7:0] opnd, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = opnd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic [2:0] op, input logic [7:0] opnd,
                     input logic [7:0] exp_res, input logic exp_zero, input logic exp_err,
                     input int exp_lat);
    int lat;
    send(op, opnd, lat);
    check({tag, "_lat"},    lat,                   exp_lat);
    check({tag, "_result"}, {24'd0, rsp_result},   {24'd0, exp_res});
    check({tag, "_zero"},   {31'd0, rsp_zero},     {31'd0, exp_zero});
    check({tag, "_err"},    {31'd0, rsp_err},      {31'd0, exp_err});
    release_rsp();
  endtask

  initial begin
    int lat;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 3'b000;
    cmd_operand = 8'h00;
    rsp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
    check("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
    check("rst_rsp_zero",   {31'd0, rsp_zero},   32'd0);
    check("rst_rsp_err",    {31'd0, rsp_err},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Single-cycle ops and wraparound
    txn("load0f", OP_LOAD, 8'h0F, 8'h0F, 1'b0, 1'b0, 1);
    txn("addf1",  OP_ADD,  8'hF1, 8'h00, 1'b1, 1'b0, 1);
    txn("load05", OP_LOAD, 8'h05, 8'h05, 1'b0, 1'b0, 1);
    txn("sub07",  OP_SUB,  8'h07, 8'hFE, 1'b0, 1'b0, 1);
    txn("and0f",  OP_AND,  8'h0F, 8'h0E, 1'b0, 1'b0, 1);
    txn("or31",   OP_OR,   8'h31, 8'h3F, 1'b0, 1'b0, 1);

    // Multiply: 0x13 * 0x0B = 0xD1, then anything * 0 = 0
    txn("load13", OP_LOAD, 8'h13, 8'h13, 1'b0, 1'b0, 1);
    txn("mul0b",  OP_MUL,  8'h0B, 8'hD1, 1'b0, 1'b0, 8);
    txn("mul00",  OP_MUL,  8'h00, 8'h00, 1'b1, 1'b0, 8);

    // Response stall with a competing command held on the input
    txn("load10", OP_LOAD, 8'h10, 8'h10, 1'b0, 1'b0, 1);
    send(OP_ADD, 8'h22, lat);
    check("stall_lat", lat, 1);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = OP_ADD;
    cmd_operand = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid",  {31'd0, rsp_valid},  32'd1);
      check("stall_result", {24'd0, rsp_result}, 32'h32);
      check("stall_zero",   {31'd0, rsp_zero},   32'd0);
      check("stall_ready",  {31'd0, cmd_ready},  32'd0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    release_rsp();

    // Reserved opcode leaves acc alone and flags an error; CLR clears it
    txn("load_aa", OP_LOAD, 8'hAA, 8'hAA, 1'b0, 1'b0, 1);
    txn("rsvd55",  OP_RSVD, 8'h55, 8'hAA, 1'b0, 1'b1, 1);
    txn("clr",     OP_CLR,  8'h77, 8'h00, 1'b1, 1'b0, 1);

    // Reset in the middle of a multiply aborts it
    txn("load13b", OP_LOAD, 8'h13, 8'h13, 1'b0, 1'b0, 1);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = OP_MUL;
    cmd_operand = 8'h0B;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid",  {31'd0, rsp_valid},  32'd0);
    check("abort_result", {24'd0, rsp_result}, 32'd0);
    check("abort_alu_a",  {24'd0, alu_a},      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) lat++;
    end
    check("abort_no_rsp", lat, 0);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    txn("add01", OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
